// File: rtl/pong_frame_streamer_if.sv
// Byte-stream handshake bundle for pong_frame_streamer.
// master drives valid/data/sof/eof, slave drives ready.
interface pong_frame_streamer_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eof;

    modport master (
        output out_valid,
        output out_data,
        output out_sof,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_sof,
        input  out_eof,
        output out_ready
    );
endinterface

// File: rtl/pong_frame_streamer.sv
// Captures pong timing-stage pixels and packs them as 2 px / 3 bytes
// into a byte FIFO with sof/eof framing and overflow frame dropping.
// Ports: clk, reset (sync, active-high), p_tick/hsync/vsync/rgb in,
//   capture_en, bus (valid/ready byte port), frame_drop, drop_count.
module pong_frame_streamer #(
    parameter int TABLE_WIDTH  = 128,
    parameter int TABLE_HEIGHT = 64,
    parameter int X_BIT_WIDTH  = 9,
    parameter int Y_BIT_WIDTH  = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_tick,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic [11:0]           rgb,
    input  logic                  capture_en,
    pong_frame_streamer_if.master bus,
    output logic                  frame_drop,
    output logic [7:0]            drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {WAIT_SYNC, STREAM} state_t;

    state_t                 r_state;
    logic [X_BIT_WIDTH-1:0] r_lx;
    logic [Y_BIT_WIDTH-1:0] r_ly;
    logic                   r_parity;
    logic [3:0]             r_pend;
    logic                   r_sof_arm;
    logic                   r_b2_vld;
    logic [7:0]             r_b2_data;
    logic                   r_b2_eof;
    logic [9:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wp;
    logic [AW-1:0]          r_rp;
    logic [AW:0]            r_cnt;
    logic                   r_drop;
    logic [7:0]             r_drop_cnt;

    logic       w_boundary;
    logic       w_active;
    logic       w_last;
    logic       w_wr;
    logic [7:0] w_wd;
    logic       w_ws;
    logic       w_we;
    logic       w_full;
    logic       w_ovf;
    logic       w_push;
    logic       w_pop;
    logic       w_valid;
    logic [9:0] w_head;

    assign w_boundary = p_tick & hsync & vsync;
    assign w_active   = p_tick && (r_state == STREAM)
                        && (r_lx <= X_BIT_WIDTH'(TABLE_WIDTH))
                        && (r_ly <= Y_BIT_WIDTH'(TABLE_HEIGHT));
    assign w_last     = (r_lx == X_BIT_WIDTH'(TABLE_WIDTH))
                        && (r_ly == Y_BIT_WIDTH'(TABLE_HEIGHT));

    // The deferred second byte never meets a sample write because
    // p_tick is only high every other clk.
    always_comb begin
        w_wr = 1'b0;
        w_wd = 8'h00;
        w_ws = 1'b0;
        w_we = 1'b0;
        if (r_b2_vld) begin
            w_wr = 1'b1;
            w_wd = r_b2_data;
            w_we = r_b2_eof;
        end else if (w_active) begin
            w_wr = 1'b1;
            if (!r_parity) begin
                w_wd = rgb[11:4];
                w_ws = r_sof_arm;
            end else begin
                w_wd = {r_pend, rgb[11:8]};
            end
        end
    end

    assign w_valid = (r_cnt != '0);
    assign w_full  = (r_cnt == DEPTH_L);
    assign w_ovf   = w_wr & w_full;
    assign w_push  = w_wr & ~w_full;
    assign w_pop   = w_valid & bus.out_ready;
    assign w_head  = r_mem[r_rp];

    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? w_head[7:0] : 8'h00;
    assign bus.out_eof   = w_valid & w_head[8];
    assign bus.out_sof   = w_valid & w_head[9];
    assign frame_drop    = r_drop;
    assign drop_count    = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {w_ws, w_we, w_wd};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= WAIT_SYNC;
            r_lx       <= '0;
            r_ly       <= '0;
            r_parity   <= 1'b0;
            r_pend     <= 4'h0;
            r_sof_arm  <= 1'b0;
            r_b2_vld   <= 1'b0;
            r_b2_data  <= 8'h00;
            r_b2_eof   <= 1'b0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_drop     <= 1'b0;
            r_drop_cnt <= 8'h00;
        end else begin
            r_drop <= w_ovf;
            if (w_ovf && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;

            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            if (w_push && !w_pop)
                r_cnt <= r_cnt + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_cnt <= r_cnt - (AW+1)'(1);

            if (p_tick) begin
                if (w_boundary) begin
                    r_lx <= '0;
                    r_ly <= '0;
                end else if (hsync) begin
                    r_lx <= '0;
                    r_ly <= r_ly + Y_BIT_WIDTH'(1);
                end else begin
                    r_lx <= r_lx + X_BIT_WIDTH'(1);
                end
            end

            if (r_b2_vld) r_b2_vld <= 1'b0;

            if (w_active) begin
                if (!r_parity) begin
                    r_parity  <= 1'b1;
                    r_pend    <= rgb[3:0];
                    r_sof_arm <= 1'b0;
                    // Odd pixel count: flush the held nibble as the last byte.
                    if (w_last) begin
                        r_b2_vld  <= 1'b1;
                        r_b2_data <= {rgb[3:0], 4'h0};
                        r_b2_eof  <= 1'b1;
                    end
                end else begin
                    r_parity  <= 1'b0;
                    r_b2_vld  <= 1'b1;
                    r_b2_data <= rgb[7:0];
                    r_b2_eof  <= w_last;
                end
            end

            case (r_state)
                WAIT_SYNC: begin
                    if (w_boundary && capture_en) begin
                        r_state   <= STREAM;
                        r_parity  <= 1'b0;
                        r_sof_arm <= 1'b1;
                    end
                end
                STREAM: begin
                    if (w_boundary) begin
                        r_parity  <= 1'b0;
                        r_sof_arm <= capture_en;
                        r_state   <= capture_en ? STREAM : WAIT_SYNC;
                    end
                end
                default: r_state <= WAIT_SYNC;
            endcase

            // Abort wins over everything: rest of frame is suppressed.
            if (w_ovf) begin
                r_state  <= WAIT_SYNC;
                r_b2_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pong_frame_streamer.sv
// Directed bench for pong_frame_streamer with a reduced 9x5 table.
// Built-in timing generator, byte monitor and packed-frame model.
module tb_pong_frame_streamer;
    localparam int TW = 8;
    localparam int TH = 4;
    localparam int HT = 12;
    localparam int VT = 7;
    localparam int FB = 68;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       p_tick;
    logic       hsync;
    logic       vsync;
    logic [11:0] rgb;
    logic       capture_en;
    logic       frame_drop;
    logic [7:0] drop_count;

    pong_frame_streamer_if bus ();

    pong_frame_streamer #(
        .TABLE_WIDTH (TW),
        .TABLE_HEIGHT(TH),
        .X_BIT_WIDTH (9),
        .Y_BIT_WIDTH (8),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .hsync     (hsync),
        .vsync     (vsync),
        .rgb       (rgb),
        .capture_en(capture_en),
        .bus       (bus),
        .frame_drop(frame_drop),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   gx = 0;
    int   gy = 0;
    int   frame_cnt = 0;
    int   drops = 0;
    logic ovr = 1'b0;
    ent_t q[$];
    ent_t exp_q[$];

    function automatic logic [11:0] pix(int x, int y);
        logic [3:0] a, b, c;
        if (ovr && x == 0 && y == 0) return 12'h123;
        if (ovr && x == 1 && y == 0) return 12'h456;
        a = 4'(x + 1);
        b = 4'(y + 5);
        c = 4'(x * 3 + y);
        return {a, b, c};
    endfunction

    function automatic void build_exp();
        int idx = 0;
        logic [11:0] p;
        logic [3:0] pend = 4'h0;
        ent_t e;
        exp_q.delete();
        for (int y = 0; y <= TH; y++) begin
            for (int x = 0; x <= TW; x++) begin
                p = pix(x, y);
                if (idx % 2 == 0) begin
                    exp_q.push_back({1'b0, 1'b0, p[11:4]});
                    pend = p[3:0];
                end else begin
                    exp_q.push_back({1'b0, 1'b0, pend, p[11:8]});
                    exp_q.push_back({1'b0, 1'b0, p[7:0]});
                end
                idx++;
            end
        end
        if (idx % 2 == 1) exp_q.push_back({1'b0, 1'b0, pend, 4'h0});
        e = exp_q[0];
        e.sof = 1'b1;
        exp_q[0] = e;
        e = exp_q[exp_q.size() - 1];
        e.eof = 1'b1;
        exp_q[exp_q.size() - 1] = e;
    endfunction

    function automatic int first_diff(int off, int n);
        if (q.size() < off + n) return -2;
        for (int i = 0; i < n; i++)
            if (q[off + i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int count_sof();
        int n = 0;
        foreach (q[i]) if (q[i].sof) n++;
        return n;
    endfunction

    function automatic int count_eof();
        int n = 0;
        foreach (q[i]) if (q[i].eof) n++;
        return n;
    endfunction

    // Timing generator: one sample every other clk, hsync on last
    // sample of a line, vsync for the whole last line.
    initial begin
        p_tick = 1'b0;
        hsync  = 1'b0;
        vsync  = 1'b0;
        rgb    = 12'h000;
        forever begin
            @(negedge clk);
            if (!p_tick) begin
                p_tick = 1'b1;
                hsync  = (gx == HT - 1);
                vsync  = (gy == VT - 1);
                rgb    = pix(gx, gy);
                if (hsync && vsync) frame_cnt++;
                if (gx == HT - 1) begin
                    gx = 0;
                    gy = (gy == VT - 1) ? 0 : gy + 1;
                end else begin
                    gx++;
                end
            end else begin
                p_tick = 1'b0;
                hsync  = 1'b0;
                vsync  = (gy == VT - 1);
            end
        end
    end

    // Byte monitor, sampled just before each active edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
                q.push_back({bus.out_sof, bus.out_eof, bus.out_data});
            if (frame_drop === 1'b1) drops++;
        end
    end

    task automatic wait_boundary();
        int start = frame_cnt;
        int t = 0;
        while (frame_cnt == start && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (frame_cnt == start) begin
            checks++;
            failures++;
            $display("FAIL boundary_timeout got=none want=frame_boundary");
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        capture_en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h want=00", bus.out_data);
        end
        checks++;
        if (bus.out_sof !== 1'b0 || bus.out_eof !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b want=00", bus.out_sof, bus.out_eof);
        end
        checks++;
        if (frame_drop !== 1'b0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_drop got=%b/%0d want=0/0", frame_drop, drop_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        int d0;
        int r;
        logic [11:0] p0;
        ent_t last;
        ovr = 1'b0;
        build_exp();
        wait_boundary();
        capture_en = 1'b1;
        q.delete();
        d0 = drops;
        wait_boundary();
        capture_en = 1'b0;
        wait_boundary();
        repeat (5) @(posedge clk);
        #1;
        p0 = pix(0, 0);
        last = (q.size() > 0) ? q[q.size() - 1] : '0;
        checks++;
        if (q.size() != FB) begin
            failures++;
            $display("FAIL full_count got=%0d want=%0d", q.size(), FB);
        end
        checks++;
        if (q.size() == 0 || q[0].sof !== 1'b1 || q[0].d !== p0[11:4]) begin
            failures++;
            $display("FAIL full_first got=%h want=sof,%h", q.size() ? q[0] : '0, p0[11:4]);
        end
        checks++;
        if (count_eof() != 1 || last.eof !== 1'b1) begin
            failures++;
            $display("FAIL full_eof got=%0d/%b want=1/1", count_eof(), last.eof);
        end
        checks++;
        if (last.d[3:0] !== 4'h0) begin
            failures++;
            $display("FAIL full_pad got=%h want=0", last.d[3:0]);
        end
        r = first_diff(0, FB);
        checks++;
        if (r != -1) begin
            failures++;
            $display("FAIL full_data got=diff_at_%0d want=match", r);
        end
        checks++;
        if (drops != d0) begin
            failures++;
            $display("FAIL full_nodrop got=%0d want=0", drops - d0);
        end
    endtask

    task automatic test_pixel_pack();
        int r;
        ovr = 1'b1;
        build_exp();
        wait_boundary();
        capture_en = 1'b1;
        q.delete();
        wait_boundary();
        capture_en = 1'b0;
        wait_boundary();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q.size() < 3 || q[0] !== {1'b1, 1'b0, 8'h12}) begin
            failures++;
            $display("FAIL pack_b0 got=%h want=212", q.size() ? q[0] : '0);
        end
        checks++;
        if (q.size() < 3 || q[1] !== {1'b0, 1'b0, 8'h34}) begin
            failures++;
            $display("FAIL pack_b1 got=%h want=034", q.size() > 1 ? q[1] : '0);
        end
        checks++;
        if (q.size() < 3 || q[2] !== {1'b0, 1'b0, 8'h56}) begin
            failures++;
            $display("FAIL pack_b2 got=%h want=056", q.size() > 2 ? q[2] : '0);
        end
        r = first_diff(0, FB);
        checks++;
        if (r != -1 || q.size() != FB) begin
            failures++;
            $display("FAIL pack_frame got=diff_%0d/size_%0d want=match/%0d", r, q.size(), FB);
        end
        ovr = 1'b0;
    endtask

    task automatic test_overflow();
        int d0;
        int r;
        int eofs;
        build_exp();
        wait_boundary();
        capture_en = 1'b1;
        bus.out_ready = 1'b0;
        q.delete();
        d0 = drops;
        wait_boundary();
        wait_boundary();
        bus.out_ready = 1'b1;
        capture_en = 1'b0;
        wait_boundary();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (drops - d0 != 1) begin
            failures++;
            $display("FAIL ovf_pulses got=%0d want=1", drops - d0);
        end
        checks++;
        if (drop_count !== 8'd1) begin
            failures++;
            $display("FAIL ovf_count got=%0d want=1", drop_count);
        end
        checks++;
        if (q.size() != 16 + FB) begin
            failures++;
            $display("FAIL ovf_size got=%0d want=%0d", q.size(), 16 + FB);
        end
        eofs = 0;
        for (int i = 0; i < 16 && i < q.size(); i++) if (q[i].eof) eofs++;
        checks++;
        if (q.size() < 17 || q[0].sof !== 1'b1 || eofs != 0) begin
            failures++;
            $display("FAIL ovf_drain got=eofs_%0d want=sof_first_no_eof", eofs);
        end
        r = first_diff(0, 16);
        checks++;
        if (r != -1) begin
            failures++;
            $display("FAIL ovf_partial got=diff_%0d want=match", r);
        end
        r = first_diff(16, FB);
        checks++;
        if (r != -1) begin
            failures++;
            $display("FAIL ovf_next got=diff_%0d want=match", r);
        end
    endtask

    task automatic test_capture_stop();
        int t = 0;
        build_exp();
        wait_boundary();
        capture_en = 1'b1;
        q.delete();
        wait_boundary();
        while (gy != 3 && t < 400) begin
            @(posedge clk);
            t++;
        end
        #1;
        capture_en = 1'b0;
        wait_boundary();
        wait_boundary();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q.size() != FB || first_diff(0, FB) != -1) begin
            failures++;
            $display("FAIL stop_frame got=size_%0d want=%0d_match", q.size(), FB);
        end
        checks++;
        if (count_sof() != 1 || count_eof() != 1) begin
            failures++;
            $display("FAIL stop_marks got=%0d/%0d want=1/1", count_sof(), count_eof());
        end
        capture_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (q.size() != FB) begin
            failures++;
            $display("FAIL stop_idle got=%0d want=%0d", q.size(), FB);
        end
        wait_boundary();
        capture_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (q.size() <= FB || q[FB].sof !== 1'b1) begin
            failures++;
            $display("FAIL stop_resume got=size_%0d want=sof_at_%0d", q.size(), FB);
        end
        wait_boundary();
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_midframe();
        build_exp();
        wait_boundary();
        capture_en = 1'b1;
        bus.out_ready = 1'b0;
        q.delete();
        wait_boundary();
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_buffered got=%b want=1", bus.out_valid);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL rst_clear got=%b/%0d want=0/0", bus.out_valid, drop_count);
        end
        bus.out_ready = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rst_quiet got=%0d want=0", q.size());
        end
        wait_boundary();
        capture_en = 1'b0;
        wait_boundary();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q.size() != FB || first_diff(0, FB) != -1) begin
            failures++;
            $display("FAIL rst_next got=size_%0d want=%0d_match", q.size(), FB);
        end
    endtask

    task automatic test_drop_saturate();
        int d0;
        wait_boundary();
        capture_en = 1'b1;
        bus.out_ready = 1'b0;
        d0 = drops;
        wait_boundary();
        for (int i = 0; i < 260; i++) wait_boundary();
        checks++;
        if (drops - d0 != 260) begin
            failures++;
            $display("FAIL sat_pulses got=%0d want=260", drops - d0);
        end
        checks++;
        if (drop_count !== 8'd255) begin
            failures++;
            $display("FAIL sat_count got=%0d want=255", drop_count);
        end
        bus.out_ready = 1'b1;
        capture_en = 1'b0;
        wait_boundary();
        repeat (5) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        capture_en = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_full_frame();
        test_pixel_pack();
        test_overflow();
        test_capture_stop();
        test_reset_midframe();
        test_drop_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pong_frame_streamer.md
Name: pong_frame_streamer

Overview:
- Downstream consumer of the pong VGA-style timing/pixel stage's p_tick, hsync, vsync and 12-bit rgb outputs.
- Rebuilds the active-pixel region from the sync pulses and packs pixels into a byte stream, two 12-bit pixels per three bytes.
- Bytes pass through a small FIFO to a valid/ready byte port, so an off-chip MCU or test harness can capture whole frames from the MPW die.
- When the consumer stalls too long, the block drops the rest of the frame cleanly and counts the dropped frames.

Parameters:
- TABLE_WIDTH, 128: last active x index; active x is 0..TABLE_WIDTH inclusive.
- TABLE_HEIGHT, 64: last active y index; active y is 0..TABLE_HEIGHT inclusive.
- X_BIT_WIDTH, 9: width of the internal x counter.
- Y_BIT_WIDTH, 8: width of the internal y counter.
- FIFO_DEPTH, 16: byte FIFO entries; must be a power of two.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- p_tick  in  1  pixel sample strobe; high every other clk.
- hsync  in  1  one-pixel pulse at end of line.
- vsync  in  1  high for the whole last line of the screen.
- rgb  in  12  pixel colour {R[3:0],G[3:0],B[3:0]}.
- capture_en  in  1  enable streaming; sampled only at frame boundaries.
- out_ready  in  1  consumer accepts byte.
- out_valid  out  1  byte available.
- out_data  out  8  byte.
- out_sof  out  1  marks the first byte of a frame.
- out_eof  out  1  marks the last byte of a frame.
- frame_drop  out  1  one-cycle pulse when a frame is aborted.
- drop_count  out  8  count of aborted frames; saturates at 255.

Behaviour:
- Reset (synchronous, active-high, one clk):
  - state = WAIT_SYNC.
  - FIFO empty, pending nibble cleared, pixel parity cleared.
  - Outputs: out_valid=0, out_data=0, out_sof=0, out_eof=0, frame_drop=0, drop_count=0.
  - Reset mid-frame discards all buffered bytes; no eof is emitted for that frame.
- Sampling: inputs are considered only on clk edges where p_tick=1 (a "sample").
- Frame boundary: a sample with hsync=1 and vsync=1.
- State WAIT_SYNC: on a frame boundary with capture_en=1 -> STREAM, with lx=0, ly=0, parity=0, next byte flagged sof. Otherwise stay in WAIT_SYNC.
- State STREAM, coordinate tracking:
  - Each sample advances lx.
  - A sample with hsync=1 sets lx=0 and increments ly.
  - A frame boundary sets lx=0, ly=0.
  - At a frame boundary: capture_en=1 stays in STREAM (new frame, sof armed); capture_en=0 goes to WAIT_SYNC. Deasserting capture_en mid-frame therefore never truncates a frame.
- Active pixel: the sample is in STREAM, lx<=TABLE_WIDTH and ly<=TABLE_HEIGHT. Pixels are indexed in raster order.
- Packing, even-index pixel A:
  - Write byte A[11:4] on the sample cycle.
  - Hold A[3:0] as the pending nibble.
- Packing, odd-index pixel B:
  - Write {pending,B[11:8]} on the sample cycle.
  - Write B[7:0] on the following clk.
- Final pixel of the frame (x=TABLE_WIDTH, y=TABLE_HEIGHT):
  - If its index is even, also write {A[3:0],4'h0} on the following clk.
  - The last byte written for the frame carries eof.
  - Defaults give 129x65=8385 pixels = 12578 bytes per frame.
- FIFO:
  - Each entry is {sof,eof,data}; at most one write per clk.
  - out_valid = not empty. out_data, out_sof and out_eof come from the FIFO head and are stable while out_valid=1 and out_ready=0.
  - Pop when out_valid and out_ready are both 1.
  - Latency: a byte written at edge N is visible on the outputs after edge N (registered head), so it can be accepted at edge N+1.
  - Simultaneous push and pop with the FIFO non-full is allowed and leaves count unchanged.
- Overflow:
  - Any write attempted while count==FIFO_DEPTH is an overflow, even if a pop occurs in the same cycle.
  - On overflow: the byte is discarded, frame_drop pulses for 1 clk, drop_count increments (held at 255 once reached), state -> WAIT_SYNC.
  - No further bytes of that frame are written, and the aborted frame gets no eof.
  - Bytes already in the FIFO still drain normally.
- Throughput: 1.5 bytes per 2 clk, so with out_ready held at 1 the FIFO never exceeds 2 entries.

Test Plan:
- Reset, then drive the full pong timing with capture_en=1 and out_ready=1 -> first byte has sof=1 and equals rgb(0,0)[11:4]; exactly 12578 bytes per frame; eof is on byte 12578 only; its low nibble is 0; frame_drop is never asserted.
- Force rgb to 12'h123 then 12'h456 at pixels 0 and 1 -> bytes 0x12, 0x34, 0x56 in order, the first with sof.
- Hold out_ready=0 for one full frame, FIFO_DEPTH=16 -> frame_drop pulses once and drop_count=1; after out_ready rises exactly 16 bytes drain (first has sof, none has eof); the next frame streams complete with sof and eof.
- Deassert capture_en at line 10 of a frame -> the current frame completes with eof; no sof follows until capture_en is reasserted and a frame boundary occurs.
- Assert reset mid-frame with 5 bytes buffered -> out_valid=0 after the reset edge; no bytes until the next frame boundary; the next byte has sof.
- Force 260 consecutive overflowed frames -> drop_count holds at 255; frame_drop still pulses once per aborted frame.
